pin_mux_ctrl: RTL

Parametrised pad-multiplexing controller for one MKR/NINA/PEX pin bank. Each pin is driven either by the GPIO peripheral (source 0, direction-controlled) or by one of SRCS-1 alternate-function outputs. Select changes are break-before-make, with a programmable dead time. Pad inputs are synchronised, edge-detected and latched as sticky events for the interrupt logic. Sits between the system interconnect's PIO/MSEL registers and the top-level tristate pad assignments.

---
 rtl/pin_mux_ctrl_if.sv | 19 +
 rtl/pin_mux_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pin_mux_ctrl_if.sv
// pin_mux_ctrl_if - select-write configuration bus for the pin bank.
//   iCFG_WR   : one-cycle write strobe
//   iCFG_ADDR : pin index being written
//   iCFG_SEL  : new source select for that pin
//   oCFG_ERR  : one-cycle pulse, the write was rejected
// master = interconnect side, slave = pin_mux_ctrl.
interface pin_mux_ctrl_if #(
   parameter int PINS  = 32,
   parameter int SELW  = 2,
   parameter int ADDRW = (PINS > 1) ? $clog2(PINS) : 1
);
   logic             iCFG_WR;
   logic [ADDRW-1:0] iCFG_ADDR;
   logic [SELW-1:0]  iCFG_SEL;
   logic             oCFG_ERR;

   modport master (output iCFG_WR, iCFG_ADDR, iCFG_SEL, input oCFG_ERR);
   modport slave  (input iCFG_WR, iCFG_ADDR, iCFG_SEL, output oCFG_ERR);
endinterface

// File: rtl/pin_mux_ctrl.sv
// pin_mux_ctrl - pad multiplexer for one pin bank.
//   Each pin is driven by GPIO (source 0) or one of SRCS-1 alternate outputs.
//   Select changes release the pad for DEAD cycles (break-before-make).
//   Pad inputs are synchronised, edge-detected and latched as sticky events.
// Ports:
//   iCLK/iRESETn          clock, async active-low reset
//   iPIN_IN               raw pad levels        oPIN_OUT/oPIN_OE  registered pad drive
//   iPIO_OUT/iPIO_DIR     GPIO source           iALT_OUT          alternate sources
//   cfg                   select-write bus      oSEL              per-pin target select
//   oSWITCHING            pin in dead time      oPIN_SYNC         synchronised input
//   oRISE/oFALL           edge pulses           iEVT_CLR/oEVT     W1C sticky edge flags
//   oIRQ                  registered OR of oEVT

// One pin: select state machine, pad drive and input/edge path.
module pin_mux_lane #(
   parameter int SRCS = 4,
   parameter int SELW = 2,
   parameter int DEAD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_hit,
   input  logic [SELW-1:0] wr_sel,
   input  logic            pio_out,
   input  logic            pio_dir,
   input  logic [SRCS-2:0] alt_out,
   input  logic            pad_in,
   input  logic            edge_en,
   input  logic            evt_clr,
   output logic [SELW-1:0] sel,
   output logic            pin_out,
   output logic            pin_oe,
   output logic            switching,
   output logic            sync,
   output logic            rise,
   output logic            fall,
   output logic            evt
);
   typedef enum logic {ST_ACTIVE, ST_DEAD} state_e;

   localparam logic [3:0] DEAD_LD = (DEAD > 0) ? 4'(DEAD - 1) : 4'd0;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic            out_q, out_d, oe_q, oe_d;
   logic            sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
   logic            rise_q, rise_d, fall_q, fall_d, evt_q, evt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      out_d   = 1'b0;
      oe_d    = 1'b0;
      if (state_q == ST_DEAD) begin
         if (cnt_q == 4'd0) state_d = ST_ACTIVE;
         else               cnt_d   = cnt_q - 4'd1;
      end
      // A changed select (re)starts the dead time, even if already in it.
      if (wr_hit && (wr_sel != sel_q)) begin
         sel_d = wr_sel;
         if (DEAD > 0) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LD;
         end
      end
      // Drive is computed from the next state so the pad releases on the
      // same edge the new select is taken.
      if (state_d == ST_ACTIVE) begin
         if (sel_d == '0) begin
            oe_d  = pio_dir;
            out_d = pio_dir & pio_out;
         end else begin
            oe_d = 1'b1;
            for (int k = 1; k < SRCS; k++)
               if (sel_d == SELW'(k)) out_d = alt_out[k-1];
         end
      end

      sync1_d = pad_in;
      sync2_d = sync1_q;
      hist_d  = sync2_q;
      rise_d  = edge_en &  sync2_q & ~hist_q;
      fall_d  = edge_en & ~sync2_q &  hist_q;
      // Set beats clear when both land in the same cycle.
      evt_d   = (evt_q & ~evt_clr) | rise_q | fall_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACTIVE;
         cnt_q   <= '0;
         sel_q   <= '0;
         out_q   <= 1'b0;
         oe_q    <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         hist_q  <= hist_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         evt_q   <= evt_d;
      end
   end

   assign sel       = sel_q;
   assign pin_out   = out_q;
   assign pin_oe    = oe_q;
   assign switching = (state_q == ST_DEAD);
   assign sync      = sync2_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign evt       = evt_q;
endmodule

module pin_mux_ctrl #(
   parameter int PINS = 32,
   parameter int SRCS = 4,
   parameter int SELW = 2,
   parameter int DEAD = 4
) (
   input  logic                     iCLK,
   input  logic                     iRESETn,
   input  logic [PINS-1:0]          iPIN_IN,
   output logic [PINS-1:0]          oPIN_OUT,
   output logic [PINS-1:0]          oPIN_OE,
   input  logic [PINS-1:0]          iPIO_OUT,
   input  logic [PINS-1:0]          iPIO_DIR,
   input  logic [(SRCS-1)*PINS-1:0] iALT_OUT,
   pin_mux_ctrl_if.slave            cfg,
   output logic [PINS*SELW-1:0]     oSEL,
   output logic [PINS-1:0]          oSWITCHING,
   output logic [PINS-1:0]          oPIN_SYNC,
   output logic [PINS-1:0]          oRISE,
   output logic [PINS-1:0]          oFALL,
   input  logic [PINS-1:0]          iEVT_CLR,
   output logic [PINS-1:0]          oEVT,
   output logic                     oIRQ
);
   logic       wr_ok, err_q, err_d, irq_q, irq_d, edge_en;
   logic [1:0] wu_q, wu_d;

   always_comb begin
      wr_ok = cfg.iCFG_WR && (int'(cfg.iCFG_ADDR) < PINS) && (int'(cfg.iCFG_SEL) < SRCS);
      err_d = cfg.iCFG_WR && !wr_ok;
      // Warm-up keeps the synchroniser's first fill from looking like an edge.
      wu_d  = (wu_q == 2'd3) ? wu_q : wu_q + 2'd1;
      irq_d = |oEVT;
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         err_q <= 1'b0;
         wu_q  <= 2'd0;
         irq_q <= 1'b0;
      end else begin
         err_q <= err_d;
         wu_q  <= wu_d;
         irq_q <= irq_d;
      end
   end

   assign edge_en      = (wu_q == 2'd3);
   assign cfg.oCFG_ERR = err_q;
   assign oIRQ         = irq_q;

   for (genvar i = 0; i < PINS; i++) begin : g_pin
      logic [SRCS-2:0] alt;
      for (genvar k = 1; k < SRCS; k++) begin : g_alt
         assign alt[k-1] = iALT_OUT[(k-1)*PINS+i];
      end

      pin_mux_lane #(.SRCS(SRCS), .SELW(SELW), .DEAD(DEAD)) u_lane (
         .clk      (iCLK),
         .rst_n    (iRESETn),
         .wr_hit   (wr_ok && (int'(cfg.iCFG_ADDR) == i)),
         .wr_sel   (cfg.iCFG_SEL),
         .pio_out  (iPIO_OUT[i]),
         .pio_dir  (iPIO_DIR[i]),
         .alt_out  (alt),
         .pad_in   (iPIN_IN[i]),
         .edge_en  (edge_en),
         .evt_clr  (iEVT_CLR[i]),
         .sel      (oSEL[i*SELW +: SELW]),
         .pin_out  (oPIN_OUT[i]),
         .pin_oe   (oPIN_OE[i]),
         .switching(oSWITCHING[i]),
         .sync     (oPIN_SYNC[i]),
         .rise     (oRISE[i]),
         .fall     (oFALL[i]),
         .evt      (oEVT[i])
      );
   end
endmodule
